// File: rtl/mem_stage_ctrl_if.sv
// Data-memory port of the MEM stage: registered strobes/address/data out, resp/rdata back.
// master = controller side, slave = memory side.
interface mem_stage_ctrl_if;
    logic [15:0] d_mem_address;
    logic        d_mem_read;
    logic        d_mem_write;
    logic [1:0]  d_mem_byte_enable;
    logic [15:0] d_mem_wdata;
    logic        d_mem_resp;
    logic [15:0] d_mem_rdata;

    modport master (
        output d_mem_address, d_mem_read, d_mem_write, d_mem_byte_enable, d_mem_wdata,
        input  d_mem_resp, d_mem_rdata
    );

    modport slave (
        input  d_mem_address, d_mem_read, d_mem_write, d_mem_byte_enable, d_mem_wdata,
        output d_mem_resp, d_mem_rdata
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// LC-3b MEM-stage controller: sequences single and indirect data accesses and stalls the pipe.
// Latency: 2 stall cycles per single access, 3 for LDI/STI, +1 per memory wait; stalls until d_mem_resp.
module mem_stage_ctrl #(
    parameter int WAIT_LIMIT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_valid,
    input  logic [3:0]      opcode,
    input  logic            ctl_read,
    input  logic            ctl_write,
    input  logic [15:0]     addr_in,
    input  logic [15:0]     wdata_in,
    mem_stage_ctrl_if.master dmem,
    output logic            mem_stall,
    output logic [15:0]     mdr_out,
    output logic            mdr_valid,
    output logic            mem_timeout
);

    localparam logic [3:0] OP_LDB  = 4'b0010;
    localparam logic [3:0] OP_STB  = 4'b0011;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_TRAP = 4'b1111;
    localparam logic [16:0] WL     = 17'(WAIT_LIMIT);

    typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_t;

    state_t      state;
    logic [3:0]  op_q;
    logic [15:0] wait_cnt;

    logic        req;
    logic        byte_op;
    logic        first_write;
    logic        indirect_q;
    logic        load_q;
    logic        in_acc;
    logic [7:0]  sel_byte;
    logic [15:0] load_data;

    assign req         = mem_valid & (ctl_read | ctl_write);
    assign byte_op     = (opcode == OP_LDB) || (opcode == OP_STB);
    // ctl_read wins over ctl_write, so a write only starts for a store opcode with no read request
    assign first_write = !ctl_read && ((opcode == OP_STR) || (opcode == OP_STB));
    assign indirect_q  = (op_q == OP_LDI) || (op_q == OP_STI);
    assign load_q      = (op_q == OP_LDR) || (op_q == OP_LDB) || (op_q == OP_LDI) || (op_q == OP_TRAP);
    assign in_acc      = (state == ACC1) || (state == ACC2);
    assign mem_stall   = ((state == IDLE) && req) || in_acc;

    assign sel_byte  = dmem.d_mem_address[0] ? dmem.d_mem_rdata[15:8] : dmem.d_mem_rdata[7:0];
    assign load_data = (op_q == OP_LDB) ? {{8{sel_byte[7]}}, sel_byte} : dmem.d_mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state                  <= IDLE;
            op_q                   <= 4'h0;
            wait_cnt               <= 16'h0;
            dmem.d_mem_address     <= 16'h0;
            dmem.d_mem_read        <= 1'b0;
            dmem.d_mem_write       <= 1'b0;
            dmem.d_mem_byte_enable <= 2'b00;
            dmem.d_mem_wdata       <= 16'h0;
            mdr_out                <= 16'h0;
            mdr_valid              <= 1'b0;
            mem_timeout            <= 1'b0;
        end else begin
            mem_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    mdr_valid <= 1'b0;
                    if (req) begin
                        state              <= ACC1;
                        op_q               <= opcode;
                        dmem.d_mem_address <= byte_op ? addr_in : (addr_in & 16'hFFFE);
                        if (first_write) begin
                            dmem.d_mem_write <= 1'b1;
                            dmem.d_mem_read  <= 1'b0;
                            if (opcode == OP_STB) begin
                                dmem.d_mem_wdata       <= {wdata_in[7:0], wdata_in[7:0]};
                                dmem.d_mem_byte_enable <= addr_in[0] ? 2'b10 : 2'b01;
                            end else begin
                                dmem.d_mem_wdata       <= wdata_in;
                                dmem.d_mem_byte_enable <= 2'b11;
                            end
                        end else begin
                            dmem.d_mem_read        <= 1'b1;
                            dmem.d_mem_write       <= 1'b0;
                            dmem.d_mem_byte_enable <= 2'b11;
                        end
                    end
                end
                ACC1: begin
                    if (dmem.d_mem_resp) begin
                        if (indirect_q) begin
                            // second access goes to the fetched pointer, word aligned
                            state                  <= ACC2;
                            dmem.d_mem_address     <= dmem.d_mem_rdata & 16'hFFFE;
                            dmem.d_mem_byte_enable <= 2'b11;
                            if (op_q == OP_STI) begin
                                dmem.d_mem_read  <= 1'b0;
                                dmem.d_mem_write <= 1'b1;
                                dmem.d_mem_wdata <= wdata_in;
                            end
                        end else begin
                            state                  <= DONE;
                            dmem.d_mem_read        <= 1'b0;
                            dmem.d_mem_write       <= 1'b0;
                            dmem.d_mem_byte_enable <= 2'b00;
                            mdr_valid              <= load_q;
                            if (load_q) begin
                                mdr_out <= load_data;
                            end
                        end
                    end
                end
                ACC2: begin
                    if (dmem.d_mem_resp) begin
                        state                  <= DONE;
                        dmem.d_mem_read        <= 1'b0;
                        dmem.d_mem_write       <= 1'b0;
                        dmem.d_mem_byte_enable <= 2'b00;
                        mdr_valid              <= (op_q == OP_LDI);
                        if (op_q == OP_LDI) begin
                            mdr_out <= dmem.d_mem_rdata;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    mdr_valid <= 1'b0;
                end
            endcase

            // watchdog: saturating count of unanswered access cycles, single pulse at the limit
            if (in_acc && !dmem.d_mem_resp) begin
                if (wait_cnt != 16'hFFFF) begin
                    wait_cnt <= wait_cnt + 16'd1;
                end
                mem_timeout <= (WAIT_LIMIT > 0) && (({1'b0, wait_cnt} + 17'd1) == WL);
            end else begin
                wait_cnt <= 16'h0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: directed instructions push expected accesses/completions,
// a monitor pops and compares on each memory handshake and at each end-of-stall.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic [3:0]  opcode;
    logic        ctl_read;
    logic        ctl_write;
    logic [15:0] addr_in;
    logic [15:0] wdata_in;
    logic        mem_stall;
    logic [15:0] mdr_out;
    logic        mdr_valid;
    logic        mem_timeout;

    always #5 clk = ~clk;

    mem_stage_ctrl_if dif ();

    mem_stage_ctrl #(.WAIT_LIMIT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_valid   (mem_valid),
        .opcode      (opcode),
        .ctl_read    (ctl_read),
        .ctl_write   (ctl_write),
        .addr_in     (addr_in),
        .wdata_in    (wdata_in),
        .dmem        (dif.master),
        .mem_stall   (mem_stall),
        .mdr_out     (mdr_out),
        .mdr_valid   (mdr_valid),
        .mem_timeout (mem_timeout)
    );

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [1:0]  be;
        logic [15:0] wdata;
    } acc_t;

    typedef struct {
        int          stalls;
        logic        vld;
        logic [15:0] mdr;
    } done_t;

    acc_t  acc_q[$];
    done_t done_q[$];
    int    checks = 0;
    int    errors = 0;
    int    to_pulses = 0;

    logic [15:0] mem [logic [15:0]];
    int          delay = 1;
    bit          no_resp = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_acc(input logic wr, input logic [15:0] a, input logic [1:0] be, input logic [15:0] wd);
        acc_t e;
        e.wr = wr; e.addr = a; e.be = be; e.wdata = wd;
        acc_q.push_back(e);
    endtask

    task automatic push_done(input int stalls, input logic vld, input logic [15:0] mdr);
        done_t e;
        e.stalls = stalls; e.vld = vld; e.mdr = mdr;
        done_q.push_back(e);
    endtask

    // memory model: resp after 'delay' strobe cycles, rdata from the word-aligned table
    initial begin
        int          wcnt;
        logic [15:0] a;
        wcnt = 0;
        dif.d_mem_resp  = 1'b0;
        dif.d_mem_rdata = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            if (dif.d_mem_resp) wcnt = 0;
            if ((dif.d_mem_read || dif.d_mem_write) && !rst) begin
                wcnt++;
                a = dif.d_mem_address & 16'hFFFE;
                if (!no_resp && wcnt >= delay) begin
                    dif.d_mem_resp  = 1'b1;
                    dif.d_mem_rdata = mem.exists(a) ? mem[a] : 16'hDEAD;
                end else begin
                    dif.d_mem_resp = 1'b0;
                end
            end else begin
                dif.d_mem_resp = 1'b0;
                wcnt = 0;
            end
        end
    end

    // monitor
    initial begin
        int    run;
        acc_t  ea;
        done_t ed;
        run = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                run = 0;
            end else begin
                if (mem_timeout) to_pulses++;
                if ((dif.d_mem_read || dif.d_mem_write) && dif.d_mem_resp) begin
                    if (acc_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL acc_unexpected: got addr %h, required no access", dif.d_mem_address);
                    end else begin
                        ea = acc_q.pop_front();
                        chk("acc_write", 32'(dif.d_mem_write), 32'(ea.wr));
                        chk("acc_read", 32'(dif.d_mem_read), 32'(!ea.wr));
                        chk("acc_addr", 32'(dif.d_mem_address), 32'(ea.addr));
                        chk("acc_be", 32'(dif.d_mem_byte_enable), 32'(ea.be));
                        if (ea.wr) chk("acc_wdata", 32'(dif.d_mem_wdata), 32'(ea.wdata));
                    end
                end
                if (mem_stall) begin
                    run++;
                end else if (run > 0) begin
                    if (done_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL done_unexpected: got %0d stall cycles, required none", run);
                    end else begin
                        ed = done_q.pop_front();
                        chk("stall_cycles", 32'(run), 32'(ed.stalls));
                        chk("mdr_valid", 32'(mdr_valid), 32'(ed.vld));
                        if (ed.vld) chk("mdr_out", 32'(mdr_out), 32'(ed.mdr));
                    end
                    run = 0;
                end
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic rd, input logic wr,
                         input logic [15:0] a, input logic [15:0] wd);
        int n;
        @(posedge clk);
        #1;
        mem_valid = 1'b1; opcode = op; ctl_read = rd; ctl_write = wr;
        addr_in = a; wdata_in = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (mem_stall && n < 60);
        if (mem_stall) begin
            checks++; errors++;
            $display("FAIL instr_hang: got stall after %0d cycles, required completion (op %h)", n, op);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int pulses;
        int pulse_k;
        rst = 1'b1; mem_valid = 1'b0; opcode = 4'h0; ctl_read = 1'b0; ctl_write = 1'b0;
        addr_in = 16'h0; wdata_in = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_read", 32'(dif.d_mem_read), 32'd0);
        chk("rst_write", 32'(dif.d_mem_write), 32'd0);
        chk("rst_be", 32'(dif.d_mem_byte_enable), 32'd0);
        chk("rst_addr", 32'(dif.d_mem_address), 32'd0);
        chk("rst_wdata", 32'(dif.d_mem_wdata), 32'd0);
        chk("rst_mdr", 32'(mdr_out), 32'd0);
        chk("rst_mdr_valid", 32'(mdr_valid), 32'd0);
        chk("rst_timeout", 32'(mem_timeout), 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1; rst = 1'b0;

        mem[16'h3004] = 16'h1234;
        mem[16'h2000] = 16'h80FF;
        mem[16'h0024] = 16'h0200;

        // LDR: bit0 cleared
        push_acc(1'b0, 16'h3004, 2'b11, 16'h0); push_done(2, 1'b1, 16'h1234);
        issue(4'b0110, 1'b1, 1'b0, 16'h3005, 16'h0);
        // LDB high byte then low byte, sign extended
        push_acc(1'b0, 16'h2001, 2'b11, 16'h0); push_done(2, 1'b1, 16'hFF80);
        issue(4'b0010, 1'b1, 1'b0, 16'h2001, 16'h0);
        push_acc(1'b0, 16'h2000, 2'b11, 16'h0); push_done(2, 1'b1, 16'hFFFF);
        issue(4'b0010, 1'b1, 1'b0, 16'h2000, 16'h0);
        // STB to odd then even address
        push_acc(1'b1, 16'h4001, 2'b10, 16'hCDCD); push_done(2, 1'b0, 16'h0);
        issue(4'b0011, 1'b0, 1'b1, 16'h4001, 16'hABCD);
        push_acc(1'b1, 16'h4000, 2'b01, 16'hCDCD); push_done(2, 1'b0, 16'h0);
        issue(4'b0011, 1'b0, 1'b1, 16'h4000, 16'hABCD);
        // non-memory instruction: no stall, nothing expected
        issue(4'b0001, 1'b0, 1'b0, 16'h1111, 16'h2222);
        // LDI with one wait cycle per access
        mem[16'h1000] = 16'h5001; mem[16'h5000] = 16'h0042; delay = 2;
        push_acc(1'b0, 16'h1000, 2'b11, 16'h0); push_acc(1'b0, 16'h5000, 2'b11, 16'h0);
        push_done(5, 1'b1, 16'h0042);
        issue(4'b1010, 1'b1, 1'b0, 16'h1000, 16'h0);
        // STI
        mem[16'h1000] = 16'h6000; delay = 1;
        push_acc(1'b0, 16'h1000, 2'b11, 16'h0); push_acc(1'b1, 16'h6000, 2'b11, 16'h7777);
        push_done(3, 1'b0, 16'h0);
        issue(4'b1011, 1'b0, 1'b1, 16'h1000, 16'h7777);
        // TRAP vector read
        push_acc(1'b0, 16'h0024, 2'b11, 16'h0); push_done(2, 1'b1, 16'h0200);
        issue(4'b1111, 1'b1, 1'b0, 16'h0025, 16'h0);
        // STR with two wait cycles
        delay = 3;
        push_acc(1'b1, 16'h3006, 2'b11, 16'hBEEF); push_done(4, 1'b0, 16'h0);
        issue(4'b0111, 1'b0, 1'b1, 16'h3007, 16'hBEEF);
        // both control bits: read wins
        delay = 1;
        push_acc(1'b0, 16'h3006, 2'b11, 16'h0); push_done(2, 1'b0, 16'h0);
        issue(4'b0111, 1'b1, 1'b1, 16'h3007, 16'hBEEF);

        // watchdog: unanswered LDR, reset during the 6th wait cycle
        no_resp = 1'b1;
        @(posedge clk); #1;
        mem_valid = 1'b1; opcode = 4'b0110; ctl_read = 1'b1; ctl_write = 1'b0; addr_in = 16'h3005;
        @(negedge clk);
        pulses = 0; pulse_k = 0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (k == 6) rst = 1'b1;
            @(negedge clk);
            if (mem_timeout) begin
                pulses++;
                pulse_k = k;
            end
        end
        chk("wd_read_held", 32'(dif.d_mem_read), 32'd1);
        chk("wd_pulses", 32'(pulses), 32'd1);
        chk("wd_pulse_cycle", 32'(pulse_k), 32'd5);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_read", 32'(dif.d_mem_read), 32'd0);
        chk("abort_be", 32'(dif.d_mem_byte_enable), 32'd0);
        chk("abort_timeout", 32'(mem_timeout), 32'd0);
        chk("abort_stall_req", 32'(mem_stall), 32'd1);
        @(posedge clk); #1; mem_valid = 1'b0;
        @(negedge clk);
        chk("abort_stall_noreq", 32'(mem_stall), 32'd0);
        @(posedge clk); #1; rst = 1'b0; no_resp = 1'b0;
        @(negedge clk);
        chk("post_rst_stall", 32'(mem_stall), 32'd0);

        push_acc(1'b0, 16'h3004, 2'b11, 16'h0); push_done(2, 1'b1, 16'h1234);
        issue(4'b0110, 1'b1, 1'b0, 16'h3005, 16'h0);
        @(posedge clk); #1; mem_valid = 1'b0; ctl_read = 1'b0;
        repeat (4) @(negedge clk);

        chk("timeout_total", 32'(to_pulses), 32'd1);
        chk("acc_q_empty", 32'(acc_q.size()), 32'd0);
        chk("done_q_empty", 32'(done_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
